code_pulse_decoder: RTL and testbench
=====================================

Name: code_pulse_decoder

Overview:
- Decoder counterpart to the 8-to-3 priority encoder: accepts 3-bit index codes over a valid/ready handshake and reconstructs each one as a one-hot 8-bit line asserted for a programmable number of cycles.
- A mandatory idle gap follows each pulse.
- Buffers up to two pending codes, so an upstream encoder or sequencer can issue back-to-back codes without stalling every cycle.
- Sits between code-producing logic and per-line strobe consumers.

Parameters:
- HOLD_CYCLES, 3, cycles the one-hot output stays asserted per code; must be >= 1.
- GAP_CYCLES, 2, cycles of all-zero output after each pulse; 0 is legal.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_code is valid
- in_ready  output  1  FIFO can accept; combinational, equal to !fifo_full
- in_code  input  3  index to decode; code k drives bit k
- out_onehot  output  8  registered one-hot pulse; all zero when not in HOLD
- out_active  output  1  high exactly while in HOLD
- done  output  1  one-cycle pulse on the last HOLD cycle of each code
- busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async assert, sync release):
  - out_onehot=0, out_active=0, done=0, busy=0.
  - FIFO flushed; state=IDLE; counters=0.
  - in_ready=1 (FIFO empty).
- Accept:
  - A code is accepted on a rising edge with in_valid && in_ready and written into a 2-entry FIFO.
  - When full, in_ready=0 even if a pop occurs that same cycle; no same-cycle push on full.
  - Push and pop in the same cycle on a non-full FIFO are both performed; occupancy is unchanged.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop at the edge, load out_onehot = 1 << code, set cnt=HOLD_CYCLES-1, go to HOLD. Otherwise stay.
  - HOLD: out_onehot held, out_active=1. If cnt==0, then done=1 this cycle and at the edge clear out_onehot and go to GAP (cnt=GAP_CYCLES-1), or go straight to IDLE when GAP_CYCLES==0. Otherwise cnt decrements.
  - GAP: out_onehot=0. If cnt==0, go to IDLE at the edge; else decrement.
- Latency and spacing:
  - Code accepted at edge N into an empty FIFO while IDLE → popped at edge N+1 → out_onehot valid from edge N+1 for HOLD_CYCLES cycles.
  - Consecutive pulses start HOLD_CYCLES+GAP_CYCLES+1 cycles apart, including the one IDLE cycle.
- Width rules:
  - Counter width is clog2(max(HOLD_CYCLES,GAP_CYCLES)+1), minimum 1.
  - Decode is exactly one bit per code; there is no invalid code.
- Reset mid-operation: immediately zeroes outputs and discards the in-flight code and all buffered codes.
- Inputs: in_code is sampled only on accept; changes while unaccepted are ignored.

Decomposition:
- Shared package:
  - state enum {IDLE, HOLD, GAP}
  - CODE_W=3, LINE_W=8
  - decode function code→one-hot (reusable by the encoder's bench as a golden model)
- Sub-module: code_fifo2, a 2-entry FIFO with full/empty and push/pop, parameterised by data width.

Test Plan:
1. Reset check: assert rst mid-stream with idle inputs → out_onehot=8'h00, out_active=0, done=0, busy=0, in_ready=1 during and after reset.
2. Single code (defaults), in_code=3'b101 accepted at edge 0 → out_onehot=8'h20 for edges 1-3, done high in cycle after edge 3, out_onehot=0 for 2 gap cycles, busy=0 after edge 6.
3. Back-to-back codes 0,7,2, in_valid held high →
   - in_ready drops after the third code is buffered (one code in HOLD, two in FIFO).
   - Pulses 8'h01, 8'h80, 8'h04 start 6 cycles apart.
   - No code lost or reordered.
4. Backpressure: in_valid=1 with in_code=3'b011 while in_ready=0; change in_code to 3'b110 before acceptance → only the value present at the accepting edge (3'b110) produces 8'h40.
5. Reset mid-HOLD: queue codes 1,4,6 and assert rst during the second HOLD cycle of code 1 → outputs zero asynchronously; after release no pulses appear; FIFO empty (in_ready=1, busy=0).
6. GAP_CYCLES=0, HOLD_CYCLES=1: codes 3,5 back-to-back → 8'h08 one cycle, one IDLE cycle, 8'h20 one cycle; done pulses in both HOLD cycles.

Source files
------------

// File: rtl/code_pulse_decoder_pkg.sv
// Shared types and helpers for the code pulse decoder: FSM states, code/line
// widths, the code-to-one-hot decode and the counter width rule.
package code_pulse_decoder_pkg;

  localparam int CODE_W = 3;
  localparam int LINE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Golden decode: code k drives exactly bit k.
  function automatic logic [LINE_W-1:0] decode_code(input logic [CODE_W-1:0] code);
    return LINE_W'(1) << code;
  endfunction

  // Counter must hold max(hold, gap); never narrower than one bit.
  function automatic int cnt_width(input int hold, input int gap);
    int max_v;
    int w;
    max_v = (hold > gap) ? hold : gap;
    w = $clog2(max_v + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/code_pulse_decoder_if.sv
// Handshake and pulse-output bundle between a code producer and the decoder.
interface code_pulse_decoder_if;
  import code_pulse_decoder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic [LINE_W-1:0] out_onehot;
  logic              out_active;
  logic              done;
  logic              busy;

  modport master (
    output in_valid, in_code,
    input  in_ready, out_onehot, out_active, done, busy
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, out_onehot, out_active, done, busy
  );

endinterface

// File: rtl/code_pulse_decoder_fifo2.sv
// Two-entry FIFO with full/empty flags; a push while full is dropped, so the
// producer must honour !full as its ready.
module code_fifo2 #(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok;
  logic             pop_ok;
  logic [1:0][DATA_W-1:0] entries;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_q, entry_d;

      always_comb begin
        entry_d = entry_q;
        if (push_ok && (wr_ptr_q == 1'(gi))) entry_d = wr_data;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry_d;
      end

      assign entries[gi] = entry_q;
    end
  endgenerate

  assign rd_data = entries[rd_ptr_q];

endmodule

// File: rtl/code_pulse_decoder.sv
// Turns buffered 3-bit index codes into timed one-hot strobes: HOLD_CYCLES of
// one-hot output, then GAP_CYCLES of silence, then one IDLE cycle.
module code_pulse_decoder
  import code_pulse_decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  code_pulse_decoder_if.slave  bus
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] onehot_q, onehot_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [CODE_W-1:0] fifo_rd;

  code_fifo2 #(.DATA_W(CODE_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.in_valid),
    .wr_data (bus.in_code),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          onehot_d = decode_code(fifo_rd);
          cnt_d    = HOLD_LOAD;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          onehot_d = '0;
          // With no gap the pulse drops straight back to IDLE.
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
    end
  end

  // in_ready deliberately ignores a same-cycle pop: a full FIFO never accepts.
  assign bus.in_ready   = !fifo_full;
  assign bus.out_onehot = onehot_q;
  assign bus.out_active = (state_q == HOLD);
  assign bus.done       = (state_q == HOLD) && (cnt_q == '0);
  assign bus.busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_code_pulse_decoder.sv
// Directed bench for code_pulse_decoder: default timing instance (3/2) and a
// minimal-timing instance (HOLD=1, GAP=0), hand-computed expectations per cycle.
module tb_code_pulse_decoder;
  import code_pulse_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  code_pulse_decoder_if ifa ();
  code_pulse_decoder_if ifb ();

  code_pulse_decoder #(.HOLD_CYCLES(3), .GAP_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  code_pulse_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Active is implied by the expected one-hot value being non-zero.
  task automatic expect_out(input string tag, input bit sel_b, input logic [7:0] oh,
                            input logic dn, input logic bsy, input logic rdy);
    if (!sel_b) begin
      check({tag, "_oh"},   32'(ifa.out_onehot), 32'(oh));
      check({tag, "_act"},  32'(ifa.out_active), 32'(|oh));
      check({tag, "_done"}, 32'(ifa.done),       32'(dn));
      check({tag, "_busy"}, 32'(ifa.busy),       32'(bsy));
      check({tag, "_rdy"},  32'(ifa.in_ready),   32'(rdy));
    end else begin
      check({tag, "_oh"},   32'(ifb.out_onehot), 32'(oh));
      check({tag, "_act"},  32'(ifb.out_active), 32'(|oh));
      check({tag, "_done"}, 32'(ifb.done),       32'(dn));
      check({tag, "_busy"}, 32'(ifb.busy),       32'(bsy));
      check({tag, "_rdy"},  32'(ifb.in_ready),   32'(rdy));
    end
  endtask

  always @(posedge clk) begin
    if (!rst && ifa.in_valid && ifa.in_ready)
      $display("[TB] dut_a accept code=%0d t=%0t", ifa.in_code, $time);
    if (!rst && ifb.in_valid && ifb.in_ready)
      $display("[TB] dut_b accept code=%0d t=%0t", ifb.in_code, $time);
  end

  logic [7:0] t2_oh   [7]  = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00};
  logic       t2_done [7]  = '{0, 0, 0, 1, 0, 0, 0};
  logic       t2_busy [7]  = '{1, 1, 1, 1, 1, 1, 0};

  logic [7:0] t3_oh   [19] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00,
                               8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00,
                               8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00};
  logic       t3_done [19] = '{0,0,0,1,0,0,0, 0,0,1,0,0,0, 0,0,1,0,0,0};
  logic       t3_busy [19] = '{1,1,1,1,1,1,1, 1,1,1,1,1,1, 1,1,1,1,1,0};
  logic       t3_rdy  [19] = '{1,1,0,0,0,0,0, 1,1,1,1,1,1, 1,1,1,1,1,1};

  logic [7:0] t6_oh   [5]  = '{8'h00, 8'h08, 8'h00, 8'h20, 8'h00};
  logic       t6_done [5]  = '{0, 1, 0, 1, 0};
  logic       t6_busy [5]  = '{1, 1, 1, 1, 0};

  initial begin
    logic seen_bad;
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_code = '0;
    ifb.in_valid = 1'b0; ifb.in_code = '0;
    repeat (2) @(negedge clk);

    // Reset state, during and after reset.
    expect_out("t1_in_rst_a", 1'b0, 8'h00, 0, 0, 1);
    expect_out("t1_in_rst_b", 1'b1, 8'h00, 0, 0, 1);
    rst = 1'b0;
    @(negedge clk);
    expect_out("t1_post_a", 1'b0, 8'h00, 0, 0, 1);

    // Single code 5 -> 0x20 for three cycles, two gap cycles.
    ifa.in_valid = 1'b1; ifa.in_code = 3'b101;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      expect_out($sformatf("t2_k%0d", k), 1'b0, t2_oh[k], t2_done[k], t2_busy[k], 1'b1);
      @(negedge clk);
    end

    // Back-to-back 0,7,2 with valid held high.
    ifa.in_valid = 1'b1; ifa.in_code = 3'd0;
    @(negedge clk);
    for (int k = 0; k < 19; k++) begin
      if (k == 0) ifa.in_code = 3'd7;
      if (k == 1) ifa.in_code = 3'd2;
      if (k == 2) ifa.in_valid = 1'b0;
      check($sformatf("t3_k%0d_oh", k),   32'(ifa.out_onehot), 32'(t3_oh[k]));
      check($sformatf("t3_k%0d_done", k), 32'(ifa.done),       32'(t3_done[k]));
      check($sformatf("t3_k%0d_busy", k), 32'(ifa.busy),       32'(t3_busy[k]));
      check($sformatf("t3_k%0d_rdy", k),  32'(ifa.in_ready),   32'(t3_rdy[k]));
      @(negedge clk);
    end

    // Backpressure: code 3 offered while full, swapped to 6 before acceptance.
    seen_bad = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_code = 3'd1;
    @(negedge clk);
    for (int k = 0; k < 25; k++) begin
      if (k == 0) ifa.in_code = 3'd2;
      if (k == 1) ifa.in_code = 3'd4;
      if (k == 2) ifa.in_code = 3'd3;
      if (k == 5) ifa.in_code = 3'd6;
      if (k == 8) ifa.in_valid = 1'b0;
      if (ifa.out_onehot == 8'h08) seen_bad = 1'b1;
      if (k == 2)  check("t4_rdy_full",  32'(ifa.in_ready), 32'(0));
      if (k == 6)  check("t4_rdy_k6",    32'(ifa.in_ready), 32'(0));
      if (k == 7)  check("t4_rdy_k7",    32'(ifa.in_ready), 32'(1));
      if (k == 8)  check("t4_rdy_k8",    32'(ifa.in_ready), 32'(0));
      if (k == 1)  check("t4_oh_code1",  32'(ifa.out_onehot), 32'(8'h02));
      if (k == 7)  check("t4_oh_code2",  32'(ifa.out_onehot), 32'(8'h04));
      if (k == 13) check("t4_oh_code4",  32'(ifa.out_onehot), 32'(8'h10));
      if (k == 19) check("t4_oh_code6",  32'(ifa.out_onehot), 32'(8'h40));
      if (k == 24) check("t4_busy_end",  32'(ifa.busy),       32'(0));
      @(negedge clk);
    end
    check("t4_no_code3", 32'(seen_bad), 32'(0));

    // Reset with idle inputs.
    #2 rst = 1'b1;
    #1 expect_out("t1_mid_rst", 1'b0, 8'h00, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_out("t1_mid_post", 1'b0, 8'h00, 0, 0, 1);

    // Reset during second HOLD cycle of code 1 with 4,6 queued.
    ifa.in_valid = 1'b1; ifa.in_code = 3'd1;
    @(negedge clk);
    ifa.in_code = 3'd4;
    @(negedge clk);
    ifa.in_code = 3'd6;
    check("t5_hold1", 32'(ifa.out_onehot), 32'(8'h02));
    @(negedge clk);
    ifa.in_valid = 1'b0;
    check("t5_hold2", 32'(ifa.out_onehot), 32'(8'h02));
    check("t5_full",  32'(ifa.in_ready),   32'(0));
    #2 rst = 1'b1;
    #1 expect_out("t5_async", 1'b0, 8'h00, 0, 0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifa.out_onehot != 8'h00 || ifa.busy) seen_bad = 1'b1;
    end
    check("t5_no_pulse", 32'(seen_bad), 32'(0));
    expect_out("t5_end", 1'b0, 8'h00, 0, 0, 1);

    // HOLD=1, GAP=0: codes 3,5 back-to-back.
    ifb.in_valid = 1'b1; ifb.in_code = 3'd3;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) ifb.in_code = 3'd5;
      if (k == 1) ifb.in_valid = 1'b0;
      expect_out($sformatf("t6_k%0d", k), 1'b1, t6_oh[k], t6_done[k], t6_busy[k], 1'b1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
